// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory handshake
// and presents a registered IF/ID slot plus a one-cycle inst_resp load pulse.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    output logic        inst_resp,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_inst_q, pend_inst_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    logic        if_valid_d;
    logic [31:0] if_pc_d;
    logic [31:0] if_inst_d;
    logic        inst_resp_d;

    // KILL keeps presenting the abandoned address until memory completes it.
    assign imem_read = (state_q != HOLD) && !rst;
    assign imem_addr = (state_q == KILL) ? kill_addr_q : pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_inst_d = pend_inst_q;
        kill_addr_d = kill_addr_q;
        if_valid_d  = if_valid;
        if_pc_d     = if_pc;
        if_inst_d   = if_inst;
        inst_resp_d = 1'b0;

        case (state_q)
            FETCH: begin
                if (stall) begin
                    if (imem_resp) begin
                        pend_inst_d = imem_rdata;
                        state_d     = HOLD;
                    end
                end else begin
                    if_valid_d = 1'b0;
                    if_inst_d  = NOP;
                    if (redirect) begin
                        pc_d = redirect_pc;
                        if (!imem_resp) begin
                            kill_addr_d = pc_q;
                            state_d     = KILL;
                        end
                    end else if (imem_resp) begin
                        if_valid_d  = 1'b1;
                        if_inst_d   = imem_rdata;
                        if_pc_d     = pc_q;
                        inst_resp_d = 1'b1;
                        pc_d        = pc_q + 32'd4;
                    end
                end
            end

            HOLD: begin
                if (!stall) begin
                    state_d = FETCH;
                    if (redirect) begin
                        if_valid_d = 1'b0;
                        if_inst_d  = NOP;
                        pc_d       = redirect_pc;
                    end else begin
                        if_valid_d  = 1'b1;
                        if_inst_d   = pend_inst_q;
                        if_pc_d     = pc_q;
                        inst_resp_d = 1'b1;
                        pc_d        = pc_q + 32'd4;
                    end
                end
            end

            KILL: begin
                if (!stall) begin
                    if_valid_d = 1'b0;
                    if_inst_d  = NOP;
                    if (redirect) pc_d = redirect_pc;
                end
                if (imem_resp) state_d = FETCH;
            end

            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            pend_inst_q <= 32'd0;
            kill_addr_q <= RESET_PC;
            if_valid    <= 1'b0;
            if_pc       <= 32'd0;
            if_inst     <= NOP;
            inst_resp   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_inst_q <= pend_inst_d;
            kill_addr_q <= kill_addr_d;
            if_valid    <= if_valid_d;
            if_pc       <= if_pc_d;
            if_inst     <= if_inst_d;
            inst_resp   <= inst_resp_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: normal fetch, stalls, redirects,
// reset from KILL/HOLD and PC wrap-around.
module tb_fetch_stage;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic        inst_resp;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_resp  (imem_resp),
        .imem_rdata (imem_rdata),
        .imem_read  (imem_read),
        .imem_addr  (imem_addr),
        .inst_resp  (inst_resp),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_inst    (if_inst)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc,
                                 input logic resp, input logic [31:0] rdata);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_resp   = resp;
        imem_rdata  = rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkSlot(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] inst, input logic resp);
        checkOutput({tag, ".if_valid"},  {31'd0, if_valid},  {31'd0, v});
        checkOutput({tag, ".if_pc"},     if_pc,              pc);
        checkOutput({tag, ".if_inst"},   if_inst,            inst);
        checkOutput({tag, ".inst_resp"}, {31'd0, inst_resp}, {31'd0, resp});
    endtask

    task automatic checkMem(input string tag, input logic rd, input logic [31:0] addr);
        checkOutput({tag, ".imem_read"}, {31'd0, imem_read}, {31'd0, rd});
        checkOutput({tag, ".imem_addr"}, imem_addr,          addr);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkMem("reset", 1'b0, 32'h60);
        checkSlot("reset", 1'b0, 32'h0, NOP_W, 1'b0);
        rst = 1'b0;
        #1;
        checkMem("post_reset", 1'b1, 32'h60);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_resp = 1'b0; imem_rdata = 32'd0;

        // Plain sequential fetch, one-cycle memory latency
        doReset();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkSlot("seq.wait0", 1'b0, 32'h0, NOP_W, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hA0);
        checkSlot("seq.i0", 1'b1, 32'h60, 32'hA0, 1'b1);
        checkMem("seq.i0", 1'b1, 32'h64);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkSlot("seq.gap0", 1'b0, 32'h60, NOP_W, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hA1);
        checkSlot("seq.i1", 1'b1, 32'h64, 32'hA1, 1'b1);
        checkMem("seq.i1", 1'b1, 32'h68);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkSlot("seq.gap1", 1'b0, 32'h64, NOP_W, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hA2);
        checkSlot("seq.i2", 1'b1, 32'h68, 32'hA2, 1'b1);
        checkMem("seq.i2", 1'b1, 32'h6C);

        // Stall spanning the 0x64 response
        doReset();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hA0);
        checkSlot("stall.i0", 1'b1, 32'h60, 32'hA0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'hA1);
        checkMem("stall.hold1", 1'b0, 32'h64);
        checkSlot("stall.hold1", 1'b0, 32'h60, NOP_W, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        checkMem("stall.hold2", 1'b0, 32'h64);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        checkSlot("stall.hold3", 1'b0, 32'h60, NOP_W, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkSlot("stall.release", 1'b1, 32'h64, 32'hA1, 1'b1);
        checkMem("stall.release", 1'b1, 32'h68);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hA2);
        checkSlot("stall.i2", 1'b1, 32'h68, 32'hA2, 1'b1);

        // Redirect while the 0x64 request is outstanding
        doReset();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hA0);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 32'd0);
        checkMem("kill.enter", 1'b1, 32'h64);
        checkSlot("kill.enter", 1'b0, 32'h60, NOP_W, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkMem("kill.wait", 1'b1, 32'h64);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
        checkMem("kill.done", 1'b1, 32'h200);
        checkSlot("kill.done", 1'b0, 32'h60, NOP_W, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hB0);
        checkSlot("kill.target", 1'b1, 32'h200, 32'hB0, 1'b1);

        // Redirect coincident with a response
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 32'hC1);
        checkSlot("coinc", 1'b0, 32'h200, NOP_W, 1'b0);
        checkMem("coinc", 1'b1, 32'h300);

        // Redirect during HOLD: ignored under stall, wins when stall drops
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'hD0);
        applyStimulus(1'b1, 1'b1, 32'h400, 1'b0, 32'd0);
        checkMem("holdredir.stalled", 1'b0, 32'h300);
        checkSlot("holdredir.stalled", 1'b0, 32'h200, NOP_W, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h400, 1'b0, 32'd0);
        checkSlot("holdredir.drop", 1'b0, 32'h200, NOP_W, 1'b0);
        checkMem("holdredir.drop", 1'b1, 32'h400);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hE0);
        checkSlot("holdredir.target", 1'b1, 32'h400, 32'hE0, 1'b1);

        // Reset while in KILL
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        checkMem("rstkill.enter", 1'b1, 32'h404);
        doReset();

        // Reset while in HOLD
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'hA0);
        checkMem("rsthold.enter", 1'b0, 32'h60);
        doReset();

        // PC wrap-around from the top of the address space
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h1234);
        checkMem("wrap.target", 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hF0);
        checkSlot("wrap.load", 1'b1, 32'hFFFF_FFFC, 32'hF0, 1'b1);
        checkMem("wrap.next", 1'b1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
